// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN calculator operand stack: default word
// width, the operation-select enum and the request priority helpers.
package rpn_pkg;

  localparam int WORD_W = 16;

  // One operation executes per cycle. This enum names which one it is.
  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_CLEAR = 3'd1,
    OP_ANS   = 3'd2,
    OP_PUSH  = 3'd3,
    OP_POP   = 3'd4
  } op_e;

  // Priority encoder over the request lines: clear > ans > push > pop.
  function automatic op_e op_select(input logic clear, input logic ans,
                                    input logic push, input logic pop);
    op_e sel;
    if (clear) begin
      sel = OP_CLEAR;
    end else if (ans) begin
      sel = OP_ANS;
    end else if (push) begin
      sel = OP_PUSH;
    end else if (pop) begin
      sel = OP_POP;
    end else begin
      sel = OP_NONE;
    end
    return sel;
  endfunction

  // True when two or more of the data-path requests compete in one cycle.
  function automatic logic multi_req(input logic ans, input logic push,
                                     input logic pop);
    return (ans & push) | (ans & pop) | (push & pop);
  endfunction

endpackage

// File: rtl/stack_regfile.sv
// Storage array for the operand stack: one synchronous write port and two
// combinational read ports (top and next-of-top). Contents are not reset;
// the owner gates the read data by the current depth.
module stack_regfile
  import rpn_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Single write port; entries only change when the stack logic commits a write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/rpn_stack.sv
// Operand stack for the RPN UART calculator. Parser pushes operands, the ALU
// writes back results (pop two, push one), and the UART reporter watches the
// status and sticky error flags. Exactly one operation commits per cycle.
module rpn_stack
  import rpn_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] push_din,
  input  logic             push_en,
  input  logic [WIDTH-1:0] ans_din,
  input  logic             ans_en,
  input  logic             pop_en,
  input  logic             clear,
  output logic [WIDTH-1:0] tos,
  output logic [WIDTH-1:0] nos,
  output logic [CW-1:0]    depth,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow,
  output logic             collision
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);

  op_e              op;
  logic             multi;
  logic [CW-1:0]    depth_nx;
  logic             overflow_nx;
  logic             underflow_nx;
  logic             collision_nx;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic [AW-1:0]    tos_addr;
  logic [AW-1:0]    nos_addr;
  logic [WIDTH-1:0] tos_raw;
  logic [WIDTH-1:0] nos_raw;

  // Indices wrap modulo 2^AW; they are only meaningful when the depth gate allows.
  assign tos_addr = depth[AW-1:0] - AW'(1);
  assign nos_addr = depth[AW-1:0] - AW'(2);

  assign op    = op_select(clear, ans_en, push_en, pop_en);
  assign multi = multi_req(ans_en, push_en, pop_en);

  // Decode the winning operation into next depth, flag updates and the write port.
  always_comb begin
    depth_nx     = depth;
    overflow_nx  = overflow;
    underflow_nx = underflow;
    we           = 1'b0;
    waddr        = '0;
    wdata        = '0;
    case (op)
      OP_CLEAR: begin
        depth_nx     = '0;
        overflow_nx  = 1'b0;
        underflow_nx = 1'b0;
      end
      OP_ANS: begin
        if (depth >= CW'(2)) begin
          we       = 1'b1;
          waddr    = nos_addr;
          wdata    = ans_din;
          depth_nx = depth - CW'(1);
        end else begin
          underflow_nx = 1'b1;
        end
      end
      OP_PUSH: begin
        if (depth < FULL_LVL) begin
          we       = 1'b1;
          waddr    = depth[AW-1:0];
          wdata    = push_din;
          depth_nx = depth + CW'(1);
        end else begin
          overflow_nx = 1'b1;
        end
      end
      OP_POP: begin
        if (depth != CW'(0)) begin
          depth_nx = depth - CW'(1);
        end else begin
          underflow_nx = 1'b1;
        end
      end
      OP_NONE: begin
        depth_nx = depth;
      end
      default: begin
        depth_nx = depth;
      end
    endcase
    // Clear wins outright; otherwise any competing requests latch the flag.
    collision_nx = (op == OP_CLEAR) ? 1'b0 : (collision | multi);
  end

  // Commit depth counter and sticky flags; reset overrides every request.
  always_ff @(posedge clk) begin
    if (rst) begin
      depth     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      collision <= 1'b0;
    end else begin
      depth     <= depth_nx;
      overflow  <= overflow_nx;
      underflow <= underflow_nx;
      collision <= collision_nx;
    end
  end

  // Reset has to block the write as well, otherwise a push on a reset edge would land.
  stack_regfile #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_regfile (
    .clk     (clk),
    .we      (we & ~rst),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a (tos_addr),
    .raddr_b (nos_addr),
    .rdata_a (tos_raw),
    .rdata_b (nos_raw)
  );

  assign tos   = (depth >= CW'(1)) ? tos_raw : '0;
  assign nos   = (depth >= CW'(2)) ? nos_raw : '0;
  assign empty = (depth == CW'(0));
  assign full  = (depth == FULL_LVL);

endmodule

// File: tb/tb_rpn_stack.sv
// Self-checking bench for rpn_stack: directed scenarios with hand-derived
// expectations, then randomized traffic against a queue-based stack model.
module tb_rpn_stack;
  import rpn_pkg::*;

  localparam int WIDTH = 16;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] push_din = '0;
  logic             push_en = 1'b0;
  logic [WIDTH-1:0] ans_din = '0;
  logic             ans_en = 1'b0;
  logic             pop_en = 1'b0;
  logic             clear = 1'b0;
  logic [WIDTH-1:0] tos, nos;
  logic [CW-1:0]    depth;
  logic             empty, full, overflow, underflow, collision;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: a plain queue with the back as the top of stack.
  logic [WIDTH-1:0] mstack[$];
  logic m_of = 1'b0, m_uf = 1'b0, m_col = 1'b0;

  rpn_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .push_din(push_din), .push_en(push_en),
    .ans_din(ans_din), .ans_en(ans_en), .pop_en(pop_en), .clear(clear),
    .tos(tos), .nos(nos), .depth(depth), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow), .collision(collision)
  );

  always #5 clk = ~clk;

  task automatic model_step(input logic r, input logic c, input logic a, input logic [WIDTH-1:0] ad,
                            input logic p, input logic [WIDTH-1:0] pd, input logic o);
    int nreq;
    op_e op;
    logic [WIDTH-1:0] tmp;
    nreq = int'(a) + int'(p) + int'(o);
    op = c ? OP_CLEAR : a ? OP_ANS : p ? OP_PUSH : o ? OP_POP : OP_NONE;
    if (r || op == OP_CLEAR) begin
      mstack.delete();
      m_of = 1'b0; m_uf = 1'b0; m_col = 1'b0;
    end else begin
      if (nreq >= 2) m_col = 1'b1;
      if (op == OP_ANS) begin
        if (mstack.size() >= 2) begin
          tmp = mstack.pop_back();
          tmp = mstack.pop_back();
          mstack.push_back(ad);
        end else m_uf = 1'b1;
      end else if (op == OP_PUSH) begin
        if (mstack.size() < DEPTH) mstack.push_back(pd);
        else m_of = 1'b1;
      end else if (op == OP_POP) begin
        if (mstack.size() >= 1) tmp = mstack.pop_back();
        else m_uf = 1'b1;
      end
    end
  endtask

  // One clock: drive after the falling edge, update the model at the rising edge, settle 1 time unit.
  task automatic cyc(input logic r, input logic c, input logic a, input logic [WIDTH-1:0] ad,
                     input logic p, input logic [WIDTH-1:0] pd, input logic o);
    @(negedge clk);
    rst = r; clear = c; ans_en = a; ans_din = ad; push_en = p; push_din = pd; pop_en = o;
    @(posedge clk);
    model_step(r, c, a, ad, p, pd, o);
    #1;
    rst = 1'b0; clear = 1'b0; ans_en = 1'b0; push_en = 1'b0; pop_en = 1'b0;
  endtask

  task automatic do_push(input logic [WIDTH-1:0] v); cyc(1'b0, 1'b0, 1'b0, '0, 1'b1, v, 1'b0); endtask
  task automatic do_ans(input logic [WIDTH-1:0] v);  cyc(1'b0, 1'b0, 1'b1, v, 1'b0, '0, 1'b0); endtask
  task automatic do_pop();                            cyc(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1); endtask
  task automatic do_clear();                          cyc(1'b0, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0); endtask

  task automatic test_reset();
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    n_chk++; if (depth !== 5'd0) begin n_fail++; $display("FAIL reset_depth actual=%0d required=0", depth); end
    n_chk++; if ({empty, full} !== 2'b10) begin n_fail++; $display("FAIL reset_empty_full actual=%b required=10", {empty, full}); end
    n_chk++; if ({tos, nos} !== 32'h0) begin n_fail++; $display("FAIL reset_tos_nos actual=%h required=0", {tos, nos}); end
    n_chk++; if ({overflow, underflow, collision} !== 3'b000) begin n_fail++; $display("FAIL reset_flags actual=%b required=000", {overflow, underflow, collision}); end
  endtask

  task automatic test_push_ans_pop();
    do_push(16'd10);
    do_push(16'd20);
    n_chk++; if (depth !== 5'd2) begin n_fail++; $display("FAIL pap_depth2 actual=%0d required=2", depth); end
    n_chk++; if (tos !== 16'd20 || nos !== 16'd10) begin n_fail++; $display("FAIL pap_tos_nos actual=%0d/%0d required=20/10", tos, nos); end
    n_chk++; if ({empty, overflow, underflow, collision} !== 4'b0000) begin n_fail++; $display("FAIL pap_status actual=%b required=0000", {empty, overflow, underflow, collision}); end
    do_ans(16'd30);
    n_chk++; if (depth !== 5'd1 || tos !== 16'd30 || nos !== 16'd0) begin n_fail++; $display("FAIL pap_ans actual=d%0d t%0d n%0d required=d1 t30 n0", depth, tos, nos); end
    do_pop();
    n_chk++; if (depth !== 5'd0 || empty !== 1'b1 || tos !== 16'd0) begin n_fail++; $display("FAIL pap_pop actual=d%0d e%b t%0d required=d0 e1 t0", depth, empty, tos); end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= DEPTH; i++) begin
      do_push(WIDTH'(i));
      if (i == DEPTH - 1) begin
        n_chk++; if (full !== 1'b0) begin n_fail++; $display("FAIL ovf_not_full_yet actual=%b required=0", full); end
      end
    end
    n_chk++; if (full !== 1'b1 || depth !== 5'd16 || tos !== 16'd16 || overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_full actual=f%b d%0d t%0d o%b required=f1 d16 t16 o0", full, depth, tos, overflow); end
    do_push(16'd99);
    n_chk++; if (depth !== 5'd16 || tos !== 16'd16 || nos !== 16'd15) begin n_fail++; $display("FAIL ovf_reject actual=d%0d t%0d n%0d required=d16 t16 n15", depth, tos, nos); end
    n_chk++; if (overflow !== 1'b1 || underflow !== 1'b0) begin n_fail++; $display("FAIL ovf_flag actual=o%b u%b required=o1 u0", overflow, underflow); end
    do_clear();
  endtask

  task automatic test_underflow();
    do_pop();
    n_chk++; if (underflow !== 1'b1 || depth !== 5'd0) begin n_fail++; $display("FAIL udf_pop actual=u%b d%0d required=u1 d0", underflow, depth); end
    do_push(16'd5);
    do_ans(16'd7);
    n_chk++; if (depth !== 5'd1 || tos !== 16'd5 || underflow !== 1'b1) begin n_fail++; $display("FAIL udf_ans actual=d%0d t%0d u%b required=d1 t5 u1", depth, tos, underflow); end
    do_clear();
    n_chk++; if (depth !== 5'd0 || {overflow, underflow, collision} !== 3'b000) begin n_fail++; $display("FAIL udf_clear actual=d%0d f%b required=d0 f000", depth, {overflow, underflow, collision}); end
  endtask

  task automatic test_collision();
    do_push(16'd10);
    do_push(16'd20);
    cyc(1'b0, 1'b0, 1'b1, 16'd8, 1'b1, 16'd3, 1'b0);
    n_chk++; if (depth !== 5'd1 || tos !== 16'd8 || collision !== 1'b1) begin n_fail++; $display("FAIL col_ans_wins actual=d%0d t%0d c%b required=d1 t8 c1", depth, tos, collision); end
    cyc(1'b0, 1'b1, 1'b0, '0, 1'b1, 16'd4, 1'b0);
    n_chk++; if (depth !== 5'd0 || collision !== 1'b0) begin n_fail++; $display("FAIL col_clear_push actual=d%0d c%b required=d0 c0", depth, collision); end
  endtask

  task automatic test_rst_mid();
    do_push(16'd1);
    do_push(16'd2);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1, 16'd3, 1'b1);
    n_chk++; if (depth !== 5'd3 || tos !== 16'd3 || collision !== 1'b1) begin n_fail++; $display("FAIL rst_pre actual=d%0d t%0d c%b required=d3 t3 c1", depth, tos, collision); end
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b1, 16'd77, 1'b0);
    n_chk++; if (depth !== 5'd0 || tos !== 16'd0 || {overflow, underflow, collision} !== 3'b000) begin n_fail++; $display("FAIL rst_mid actual=d%0d t%0d f%b required=d0 t0 f000", depth, tos, {overflow, underflow, collision}); end
  endtask

  task automatic test_random();
    logic c, a, p, o;
    logic [WIDTH-1:0] exp_tos, exp_nos;
    int sz;
    do_clear();
    for (int i = 0; i < 400; i++) begin
      c = ($urandom_range(0, 99) < 3);
      a = ($urandom_range(0, 99) < 20);
      p = ($urandom_range(0, 99) < 50);
      o = ($urandom_range(0, 99) < 22);
      cyc(1'b0, c, a, WIDTH'($urandom), p, WIDTH'($urandom), o);
      sz = mstack.size();
      exp_tos = (sz >= 1) ? mstack[sz-1] : '0;
      exp_nos = (sz >= 2) ? mstack[sz-2] : '0;
      n_chk++; if (depth !== CW'(sz)) begin n_fail++; $display("FAIL rnd_depth cyc=%0d actual=%0d required=%0d", i, depth, sz); end
      n_chk++; if (tos !== exp_tos || nos !== exp_nos) begin n_fail++; $display("FAIL rnd_data cyc=%0d actual=%h/%h required=%h/%h", i, tos, nos, exp_tos, exp_nos); end
      n_chk++; if ({overflow, underflow, collision, empty, full} !== {m_of, m_uf, m_col, sz == 0, sz == DEPTH}) begin
        n_fail++; $display("FAIL rnd_flags cyc=%0d actual=%b required=%b", i, {overflow, underflow, collision, empty, full}, {m_of, m_uf, m_col, sz == 0, sz == DEPTH});
      end
    end
  endtask

  initial begin
    test_reset();
    test_push_ans_pop();
    test_overflow();
    test_underflow();
    test_collision();
    test_rst_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
